// File: rtl/riscv_mc_pkg.sv
// Shared definitions for the multi-cycle RISC-V control path.
// State encodings, opcode values, ALU operation codes and datapath mux
// select codes. The datapath muxes and the bench use the same definitions.
package riscv_mc_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_EXEC_LUI = 4'd5,
        S_ALU_WB   = 4'd6,
        S_MEM_ADDR = 4'd7,
        S_MEM_RD   = 4'd8,
        S_MEM_WB   = 4'd9,
        S_MEM_WR   = 4'd10,
        S_BRANCH   = 4'd11,
        S_JAL      = 4'd12,
        S_TRAP     = 4'd13
    } state_e;

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_I      = 7'h13;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    localparam logic [2:0] ALU_R_FUNCT = 3'b000;
    localparam logic [2:0] ALU_I_FUNCT = 3'b001;
    localparam logic [2:0] ALU_ADD     = 3'b010;
    localparam logic [2:0] ALU_SUB     = 3'b011;
    localparam logic [2:0] ALU_PASS_B  = 3'b100;

    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_RS1    = 2'b01;
    localparam logic [1:0] SRCA_OLD_PC = 2'b10;

    localparam logic [1:0] SRCB_RS2    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;

    localparam logic [1:0] WB_ALU_OUT  = 2'b00;
    localparam logic [1:0] WB_MDR      = 2'b01;
    localparam logic [1:0] WB_PC       = 2'b10;

    // States that stall on the memory ready handshake and are timed.
    function automatic logic is_wait_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait timer: counts consecutive not-ready cycles in a memory state.
// Ports:
//   clk      in  core clock
//   reset    in  asynchronous, active-low
//   clear    in  zero the count (state entry or ready seen)
//   inc      in  count one more not-ready cycle (saturating)
//   at_limit out count equals MEM_TIMEOUT-1; never set when MEM_TIMEOUT is 0
// CNT_W must be wide enough to hold MEM_TIMEOUT.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic at_limit
);

    localparam bit               ENABLE = (MEM_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] LIMIT  = ENABLE ? CNT_W'(MEM_TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count;

    // With the timeout disabled the counter is held at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (!ENABLE || clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

    assign at_limit = ENABLE && (count == LIMIT);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control sequencer: steps the shared datapath through
// fetch/decode/execute/memory/write-back phases, stalls on memory ready,
// traps on an illegal opcode or a memory timeout.
// Ports:
//   clk, reset (async active-low), Op_i (IR[6:0]), Mem_Ready_i
//   PC_Write_o, Branch_o, PC_Src_o, IR_Write_o, I_or_D_o, Mem_Read_o,
//   Mem_Write_o, Reg_Write_o, Mem_to_Reg_o[1:0], ALU_Src_A_o[1:0],
//   ALU_Src_B_o[1:0], ALU_Op_o[2:0], Retire_o, Error_o, State_o[3:0]
//
// state      | meaning
// IDLE       | one cycle after reset release, no strobes
// FETCH      | read instruction at PC, PC+4 into PC on ready
// DECODE     | branch/jump target into ALU_Out, dispatch on opcode
// EXEC_R     | ALU rs1 op rs2
// EXEC_I     | ALU rs1 op imm
// EXEC_LUI   | ALU passes immediate
// ALU_WB     | ALU_Out into rd, retire
// MEM_ADDR   | rs1 + imm effective address
// MEM_RD     | data read at ALU_Out, wait ready
// MEM_WB     | MDR into rd, retire
// MEM_WR     | data write at ALU_Out, retire on ready
// BRANCH     | compare rs1/rs2, conditional PC load, retire
// JAL        | PC <- target, rd <- link, retire
// TRAP       | error, sticky until reset
module multicycle_control_fsm
    import riscv_mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] Op_i,
    input  logic       Mem_Ready_i,
    output logic       PC_Write_o,
    output logic       Branch_o,
    output logic       PC_Src_o,
    output logic       IR_Write_o,
    output logic       I_or_D_o,
    output logic       Mem_Read_o,
    output logic       Mem_Write_o,
    output logic       Reg_Write_o,
    output logic [1:0] Mem_to_Reg_o,
    output logic [1:0] ALU_Src_A_o,
    output logic [1:0] ALU_Src_B_o,
    output logic [2:0] ALU_Op_o,
    output logic       Retire_o,
    output logic       Error_o,
    output logic [3:0] State_o
);

    state_e state;
    state_e state_nxt;
    logic   in_wait;
    logic   timer_clear;
    logic   timer_inc;
    logic   timer_at_limit;
    logic   timeout_hit;

    assign in_wait     = is_wait_state(state);
    // Ready in the limit cycle wins over the timeout.
    assign timeout_hit = in_wait && !Mem_Ready_i && timer_at_limit;
    assign timer_inc   = in_wait && !Mem_Ready_i;
    assign timer_clear = (in_wait && Mem_Ready_i) ||
                         (is_wait_state(state_nxt) && (state_nxt != state));

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) u_mem_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .inc     (timer_inc),
        .at_limit(timer_at_limit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     state_nxt = S_FETCH;
            S_FETCH: begin
                if (Mem_Ready_i)      state_nxt = S_DECODE;
                else if (timeout_hit) state_nxt = S_TRAP;
            end
            S_DECODE: begin
                case (Op_i)
                    OP_R:                state_nxt = S_EXEC_R;
                    OP_I:                state_nxt = S_EXEC_I;
                    OP_LUI:              state_nxt = S_EXEC_LUI;
                    OP_LOAD, OP_STORE:   state_nxt = S_MEM_ADDR;
                    OP_BRANCH:           state_nxt = S_BRANCH;
                    OP_JAL:              state_nxt = S_JAL;
                    default:             state_nxt = S_TRAP;
                endcase
            end
            S_EXEC_R, S_EXEC_I, S_EXEC_LUI:
                        state_nxt = S_ALU_WB;
            // IR is stable here, so the opcode still tells load from store.
            S_MEM_ADDR: state_nxt = (Op_i == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (Mem_Ready_i)      state_nxt = S_MEM_WB;
                else if (timeout_hit) state_nxt = S_TRAP;
            end
            S_MEM_WR: begin
                if (Mem_Ready_i)      state_nxt = S_FETCH;
                else if (timeout_hit) state_nxt = S_TRAP;
            end
            S_ALU_WB, S_MEM_WB, S_BRANCH, S_JAL:
                        state_nxt = S_FETCH;
            S_TRAP:     state_nxt = S_TRAP;
            default:    state_nxt = S_TRAP;
        endcase
    end

    always_comb begin
        PC_Write_o   = 1'b0;
        Branch_o     = 1'b0;
        PC_Src_o     = 1'b0;
        IR_Write_o   = 1'b0;
        I_or_D_o     = 1'b0;
        Mem_Read_o   = 1'b0;
        Mem_Write_o  = 1'b0;
        Reg_Write_o  = 1'b0;
        Mem_to_Reg_o = WB_ALU_OUT;
        ALU_Src_A_o  = SRCA_PC;
        ALU_Src_B_o  = SRCB_RS2;
        ALU_Op_o     = ALU_R_FUNCT;
        Retire_o     = 1'b0;
        Error_o      = 1'b0;
        case (state)
            S_FETCH: begin
                Mem_Read_o  = 1'b1;
                ALU_Src_A_o = SRCA_PC;
                ALU_Src_B_o = SRCB_FOUR;
                ALU_Op_o    = ALU_ADD;
                IR_Write_o  = Mem_Ready_i;
                PC_Write_o  = Mem_Ready_i;
            end
            S_DECODE: begin
                ALU_Src_A_o = SRCA_OLD_PC;
                ALU_Src_B_o = SRCB_IMM;
                ALU_Op_o    = ALU_ADD;
            end
            S_EXEC_R: begin
                ALU_Src_A_o = SRCA_RS1;
                ALU_Src_B_o = SRCB_RS2;
                ALU_Op_o    = ALU_R_FUNCT;
            end
            S_EXEC_I: begin
                ALU_Src_A_o = SRCA_RS1;
                ALU_Src_B_o = SRCB_IMM;
                ALU_Op_o    = ALU_I_FUNCT;
            end
            S_EXEC_LUI: begin
                ALU_Src_B_o = SRCB_IMM;
                ALU_Op_o    = ALU_PASS_B;
            end
            S_ALU_WB: begin
                Reg_Write_o  = 1'b1;
                Mem_to_Reg_o = WB_ALU_OUT;
                Retire_o     = 1'b1;
            end
            S_MEM_ADDR: begin
                ALU_Src_A_o = SRCA_RS1;
                ALU_Src_B_o = SRCB_IMM;
                ALU_Op_o    = ALU_ADD;
            end
            S_MEM_RD: begin
                Mem_Read_o = 1'b1;
                I_or_D_o   = 1'b1;
            end
            S_MEM_WB: begin
                Reg_Write_o  = 1'b1;
                Mem_to_Reg_o = WB_MDR;
                Retire_o     = 1'b1;
            end
            S_MEM_WR: begin
                Mem_Write_o = 1'b1;
                I_or_D_o    = 1'b1;
                Retire_o    = Mem_Ready_i;
            end
            S_BRANCH: begin
                ALU_Src_A_o = SRCA_RS1;
                ALU_Src_B_o = SRCB_RS2;
                ALU_Op_o    = ALU_SUB;
                Branch_o    = 1'b1;
                PC_Src_o    = 1'b1;
                Retire_o    = 1'b1;
            end
            S_JAL: begin
                PC_Write_o   = 1'b1;
                PC_Src_o     = 1'b1;
                Reg_Write_o  = 1'b1;
                Mem_to_Reg_o = WB_PC;
                Retire_o     = 1'b1;
            end
            S_TRAP: begin
                Error_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign State_o = state;

endmodule
